rr_mux_arbiter: RTL

//   Round-robin arbiter sharing one mux-based datapath among N requesters.

---
 rtl/rr_mux_arbiter_if.sv | 15 +
 rtl/rr_mux_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between the requesting engines and rr_mux_arbiter.
// master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if #(
   parameter int N     = 4,
   parameter int SEL_W = 2
);
   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic [SEL_W-1:0] sel;
   logic             busy;
   logic             tmo;

   modport master (output req, input gnt, input sel, input busy, input tmo);
   modport slave  (input req, output gnt, output sel, output busy, output tmo);
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter driving the select bus of a shared mux tree.
// Optional forced release after MAX_HOLD cycles under contention: define ARB_TIMEOUT_EN.
module rr_mux_arbiter #(
   parameter int N        = 4,
   parameter int SEL_W    = 2,
   parameter int MAX_HOLD = 8
) (
   input logic           clk,
   input logic           rst_n,
   rr_mux_arbiter_if.slave arb
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(N - 1);

   if (SEL_W != $clog2(N) || N < 2 || N > 16 || MAX_HOLD < 2) begin : g_bad_param
      $error("rr_mux_arbiter: inconsistent N/SEL_W/MAX_HOLD");
   end

   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic             busy_q, busy_d;

   logic [SEL_W-1:0] cand;
   logic [SEL_W-1:0] win_idx;
   logic             win_found;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             others_req;

   assign others_req = |(arb.req & ~gnt_q);
`endif

   // Scan starts just after the previous owner so every requester gets its turn.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N; i++) begin
         cand = SEL_W'((int'(last_q) + i) % N);
         if (!win_found && arb.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               sel_d          = win_idx;
               last_d         = win_idx;
               busy_d         = 1'b1;
               state_d        = GRANT;
`ifdef ARB_TIMEOUT_EN
               cnt_d          = '0;
`endif
            end
         end
         GRANT: begin
            if (!arb.req[sel_q]) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               state_d = TURN;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == CNT_MAX && others_req) begin
               gnt_d   = '0;
               busy_d  = 1'b0;
               tmo_d   = 1'b1;
               state_d = TURN;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         // Dead cycle: sel keeps pointing at the old owner while the mux settles.
         TURN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= LAST_INIT;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign arb.tmo = tmo_q;
`else
   assign arb.tmo = 1'b0;
`endif

   assign arb.gnt  = gnt_q;
   assign arb.sel  = sel_q;
   assign arb.busy = busy_q;

endmodule
